mux_arb_reg: RTL and testbench

Registered, parametrised N-input arbitrating multiplexer with valid/ready handshakes on every input channel and on the output. It is the sequential successor to the team's combinational tree muxes. Instead of taking an external select, it picks a requesting channel itself, by fixed priority or round-robin, and presents the chosen word from an output register. It sits between multiple producers (e.g. fetch/load/store request sources) and one shared consumer port.

---
 rtl/mux_arb_reg.sv | 115 +++++++++++
 tb/tb_mux_arb_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_reg
// Brief    : Registered N-input arbitrating mux with valid/ready handshakes,
//            using fixed-priority or round-robin selection.
// Revision : 1.0 - initial release
// ============================================================================
module mux_arb_reg #(
  parameter int N        = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [CHANNELS-1:0]   in_valid,
  input  logic [CHANNELS*N-1:0] in_data,
  output logic [CHANNELS-1:0]   in_ready,
  output logic                  out_valid,
  output logic [N-1:0]          out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready,
  output logic [15:0]           out_count
);

  // After reset the round-robin search begins just past the last channel, i.e. at 0.
  localparam logic [SEL_W-1:0] c_PTR_RST = SEL_W'(CHANNELS - 1);

  logic [N-1:0]        w_chan_data [CHANNELS];
  logic                w_load;
  logic                w_any;
  logic [SEL_W-1:0]    w_win;
  logic [SEL_W-1:0]    w_idx;
  logic [CHANNELS-1:0] w_ready;
  logic                w_in_xfer;
  logic                w_out_xfer;

  logic                r_out_valid;
  logic [N-1:0]        r_out_data;
  logic [SEL_W-1:0]    r_out_sel;
  logic [15:0]         r_count;
  logic [SEL_W-1:0]    r_ptr;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_unpack
      assign w_chan_data[g] = in_data[g*N +: N];
    end
  endgenerate

  assign w_load     = ~r_out_valid | out_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_in_xfer  = w_any & w_load;

  // Searches run from the far end back so the last hit is the highest-priority one.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    if (!mode) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          w_any = 1'b1;
          w_win = i[SEL_W-1:0];
        end
      end
    end else begin
      for (int i = CHANNELS; i >= 1; i--) begin
        w_idx = r_ptr + i[SEL_W-1:0];
        if (in_valid[w_idx]) begin
          w_any = 1'b1;
          w_win = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_ready        = '0;
    w_ready[w_win] = w_any & w_load & rst;
  end

  assign in_ready = w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_count     <= '0;
      r_ptr       <= c_PTR_RST;
    end else begin
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_chan_data[w_win];
        r_out_sel   <= w_win;
        if (mode) begin
          r_ptr <= w_win;
        end
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (w_out_xfer) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arb_reg
// Brief    : Directed, table-driven bench for mux_arb_reg (N=32, CHANNELS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arb_reg;

  localparam int N  = 32;
  localparam int CH = 4;

  logic          clk;
  logic          rst;
  logic          mode;
  logic [CH-1:0] in_valid;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0] in_ready;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic [1:0]    out_sel;
  logic          out_ready;
  logic [15:0]   out_count;

  int n_cmp  = 0;
  int n_fail = 0;

  mux_arb_reg #(.N(N), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Registered columns show the state left by the previous vector's edge.
    // Channel k carries 32'h11111111*(k+1) throughout the table.
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd2, 32'hDEADBEEF, 16'd1};
    tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h11111111, 16'd1};
    tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h22222222, 16'd2};
    tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h33333333, 16'd3};
    tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h44444444, 16'd4};
    tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h11111111, 16'd5};
    tbl[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h22222222, 16'd6};
    tbl[7]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h33333333, 16'd7};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h44444444, 16'd8};
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h11111111, 16'd9};
    tbl[10] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h11111111, 16'd10};
    tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h11111111, 16'd11};
    tbl[12] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h11111111, 16'd12};
    tbl[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h22222222, 16'd13};
    tbl[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h22222222, 16'd13};
    tbl[15] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h22222222, 16'd13};
    tbl[16] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h22222222, 16'd13};
    tbl[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h22222222, 16'd13};
    tbl[18] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd1, 32'h22222222, 16'd13};
    tbl[19] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h11111111, 16'd14};
    tbl[20] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h11111111, 16'd15};
    // Pointer stays at 3 through mode-0 grants, so round-robin resumes at channel 0.
    tbl[21] = '{1'b1, 4'b1001, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h11111111, 16'd15};
    tbl[22] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0, 32'h11111111, 16'd15};
    tbl[23] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'h44444444, 16'd16};
    tbl[24] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'h44444444, 16'd17};

    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_sel",   64'(out_sel),   64'd0);
    chk("reset_data",  64'(out_data),  64'd0);
    chk("reset_count", 64'(out_count), 64'd0);
    chk("reset_ready", 64'(in_ready),  64'd0);

    // Single transfer from channel 2.
    rst      = 1'b1;
    in_valid = 4'b0100;
    in_data[2*N +: N] = 32'hDEADBEEF;
    #1 chk("first_ready", 64'(in_ready), 64'b0100);
    @(negedge clk);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_data",  64'(out_data),  64'hDEADBEEF);
    chk("first_sel",   64'(out_sel),   64'd2);
    in_valid = 4'b0000;
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(out_count), 64'd1);

    for (int k = 0; k < CH; k++) in_data[k*N +: N] = 32'h11111111 * (k + 1);

    for (int i = 0; i < 25; i++) begin
      mode      = tbl[i].mode;
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(in_ready),  64'(tbl[i].exp_rdy));
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_vld));
      chk($sformatf("v%0d_sel",   i), 64'(out_sel),   64'(tbl[i].exp_sel));
      chk($sformatf("v%0d_data",  i), 64'(out_data),  64'(tbl[i].exp_data));
      chk($sformatf("v%0d_count", i), 64'(out_count), 64'(tbl[i].exp_cnt));
      @(negedge clk);
    end

    // Count wrap: from 17, the first edge only loads, then one transfer per edge.
    mode      = 1'b0;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    repeat (65518) @(posedge clk);
    @(negedge clk);
    chk("count_fffe", 64'(out_count), 64'hFFFE);
    @(negedge clk);
    chk("count_ffff", 64'(out_count), 64'hFFFF);
    @(negedge clk);
    chk("count_wrap", 64'(out_count), 64'h0000);

    // Asynchronous reset while the slot is held under backpressure.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    @(negedge clk);
    chk("held_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_count", 64'(out_count), 64'd0);
    chk("async_ready", 64'(in_ready),  64'd0);
    @(negedge clk);
    rst       = 1'b1;
    mode      = 1'b1;
    out_ready = 1'b1;
    #1 chk("post_rst_ready", 64'(in_ready), 64'b0001);
    @(negedge clk);
    chk("post_rst_sel",   64'(out_sel),   64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data",  64'(out_data),  64'h11111111);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
